// File: rtl/kronos_alu_issue.sv
// Operand-issue stage for the Kronos ALU. It decodes OP, OP-IMM, LUI and
// AUIPC into op1/op2/aluop and holds the result in a valid/ready pipeline
// register that feeds the execute stage.
module kronos_alu_issue (
    input  logic        clk,
    input  logic        rstz,
    input  logic        flush,
    input  logic        instr_vld,
    output logic        instr_rdy,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  aluop,
    output logic [4:0]  rd,
    output logic        rd_write,
    output logic        illegal
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned REG_W   = 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_u;

    logic [XLEN-1:0]    dec_op1;
    logic [XLEN-1:0]    dec_op2;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [REG_W-1:0]   dec_rd;
    logic               dec_illegal;
    logic               dec_rd_write;

    logic               out_vld_q,  out_vld_d;
    logic [XLEN-1:0]    op1_q,      op1_d;
    logic [XLEN-1:0]    op2_q,      op2_d;
    logic [ALUOP_W-1:0] aluop_q,    aluop_d;
    logic [REG_W-1:0]   rd_q,       rd_d;
    logic               rd_write_q, rd_write_d;
    logic               illegal_q,  illegal_d;

    logic               accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign dec_rd = instr[11:7];

    // Combinational decode of the incoming instruction into ALU operands.
    always_comb begin
        dec_illegal = 1'b1;
        dec_op1     = '0;
        dec_op2     = '0;
        dec_aluop   = ALU_ADD;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_OP_IMM: begin
                    dec_illegal = 1'b0;
                    dec_op1     = rs1_data;
                    dec_op2     = imm_i;
                    dec_aluop   = {1'b0, funct3};
                    if (funct3 == 3'b001 && funct7 != F7_ZERO) begin
                        dec_illegal = 1'b1;
                    end
                    if (funct3 == 3'b101) begin
                        dec_aluop = {instr[30], 3'b101};
                        if (funct7 != F7_ZERO && funct7 != F7_ALT) begin
                            dec_illegal = 1'b1;
                        end
                    end
                end
                OPC_OP: begin
                    dec_op1   = rs1_data;
                    dec_op2   = rs2_data;
                    dec_aluop = {instr[30], funct3};
                    if (funct7 == F7_ZERO) begin
                        dec_illegal = 1'b0;
                    end else if (funct7 == F7_ALT &&
                                 (funct3 == 3'b000 || funct3 == 3'b101)) begin
                        dec_illegal = 1'b0;
                    end
                end
                OPC_LUI: begin
                    dec_illegal = 1'b0;
                    dec_op2     = imm_u;
                end
                OPC_AUIPC: begin
                    dec_illegal = 1'b0;
                    dec_op1     = pc;
                    dec_op2     = imm_u;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        // Illegal instructions carry a neutral payload so execute sees ADD 0+0.
        if (dec_illegal) begin
            dec_op1   = '0;
            dec_op2   = '0;
            dec_aluop = ALU_ADD;
        end
    end

    assign dec_rd_write = ~dec_illegal & (dec_rd != '0);
    assign instr_rdy    = ~out_vld_q | out_rdy;
    assign accept       = instr_vld & instr_rdy;

    // Pipeline register next state: flush, then accept, then drain.
    always_comb begin
        out_vld_d  = out_vld_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        aluop_d    = aluop_q;
        rd_d       = rd_q;
        rd_write_d = rd_write_q;
        illegal_d  = illegal_q;
        if (flush) begin
            out_vld_d = 1'b0;
        end else if (accept) begin
            out_vld_d  = 1'b1;
            op1_d      = dec_op1;
            op2_d      = dec_op2;
            aluop_d    = dec_aluop;
            rd_d       = dec_rd;
            rd_write_d = dec_rd_write;
            illegal_d  = dec_illegal;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            out_vld_q  <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            aluop_q    <= '0;
            rd_q       <= '0;
            rd_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            aluop_q    <= aluop_d;
            rd_q       <= rd_d;
            rd_write_q <= rd_write_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign op1      = op1_q;
    assign op2      = op2_q;
    assign aluop    = aluop_q;
    assign rd       = rd_q;
    assign rd_write = rd_write_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_kronos_alu_issue.sv
// Self-checking bench for kronos_alu_issue: directed scenarios plus a
// randomized run scored against a behavioural decode model.
module tb_kronos_alu_issue;

    typedef struct packed {
        logic        vld;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic        rd_write;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstz = 1'b1;
    logic        flush = 1'b0;
    logic        instr_vld = 1'b0;
    logic        instr_rdy;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        rd_write;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    kronos_alu_issue dut (
        .clk(clk), .rstz(rstz), .flush(flush),
        .instr_vld(instr_vld), .instr_rdy(instr_rdy),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .op1(op1), .op2(op2), .aluop(aluop), .rd(rd),
        .rd_write(rd_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o = {out_vld, op1, op2, aluop, rd, rd_write, illegal};
        return o;
    endfunction

    function automatic exp_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] f, input logic [4:0] d,
                                input logic w, input logic il);
        exp_t e;
        e = {v, a, b, f, d, w, il};
        return e;
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        bit          ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm12;
        e     = '0;
        ok    = 1'b0;
        f7    = i[31:25];
        f3    = i[14:12];
        imm12 = 32'(i[31:20]);
        e.vld = 1'b1;
        e.rd  = i[11:7];
        if (i[1:0] == 2'b11) begin
            case (i[6:0])
                7'b0010011: begin
                    if (f3 == 3'd1)      ok = (f7 == 7'h00);
                    else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                    else                 ok = 1'b1;
                    e.op1   = a;
                    e.op2   = i[31] ? imm12 - 32'h1000 : imm12;
                    e.aluop = (f3 == 3'd5) ? {i[30], 3'd5} : {1'b0, f3};
                end
                7'b0110011: begin
                    ok      = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    e.op1   = a;
                    e.op2   = b;
                    e.aluop = {i[30], f3};
                end
                7'b0110111: begin
                    ok    = 1'b1;
                    e.op2 = i & 32'hFFFF_F000;
                end
                7'b0010111: begin
                    ok    = 1'b1;
                    e.op1 = p;
                    e.op2 = i & 32'hFFFF_F000;
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            e.op1   = '0;
            e.op2   = '0;
            e.aluop = '0;
        end
        e.illegal  = !ok;
        e.rd_write = ok && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  f7s [3];
        w      = $urandom;
        f7s[0] = 7'h00;
        f7s[1] = 7'h20;
        f7s[2] = 7'($urandom);
        case ($urandom_range(0, 5))
            0: begin w[6:0] = 7'b0110011; w[31:25] = f7s[$urandom_range(0, 2)]; end
            1: begin w[6:0] = 7'b0010011; w[31:25] = f7s[$urandom_range(0, 2)]; end
            2: w[6:0] = 7'b0110111;
            3: w[6:0] = 7'b0010111;
            4: ;
            default: begin
                w[6:0] = 7'b0010011;
                w[1:0] = 2'($urandom_range(0, 2));
            end
        endcase
        return w;
    endfunction

    // Present one instruction at the falling edge and clock it in.
    task automatic issue(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        instr_vld = 1'b1; instr = i; pc = p; rs1_data = a; rs2_data = b;
        @(posedge clk); @(negedge clk);
        instr_vld = 1'b0;
    endtask

    task automatic drain();
        instr_vld = 1'b0; out_rdy = 1'b1; flush = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        #1 rstz = 1'b0;
        #3;
        e = mk(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL reset_state: got %h want %h", obs(), e); end
        n_vec++;
        if (instr_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", instr_rdy); end
        @(negedge clk); rstz = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        exp_t e;
        out_rdy = 1'b1;
        issue(32'hFFF08093, 32'h0, 32'd5, 32'h0);
        e = mk(1, 32'd5, 32'hFFFF_FFFF, 4'b0000, 5'd1, 1, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL addi: got %h want %h", obs(), e); end
        drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_rdy = 1'b1;
        instr_vld = 1'b1; instr = 32'h40208133; rs1_data = 32'h8000_0010; rs2_data = 32'd7;
        @(posedge clk); @(negedge clk);
        e = mk(1, 32'h8000_0010, 32'd7, 4'b1000, 5'd2, 1, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL sub: got %h want %h", obs(), e); end
        instr = 32'h4030D113; rs1_data = 32'h8000_0010; rs2_data = 32'd9;
        #1;
        n_vec++;
        if (instr_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy: got %b want 1", instr_rdy); end
        @(posedge clk); @(negedge clk);
        e = mk(1, 32'h8000_0010, 32'h0000_0403, 4'b1101, 5'd2, 1, 0);
        n_vec++;
        if (obs() !== e || op2[4:0] !== 5'd3) begin
            n_err++; $display("FAIL srai: got %h want %h", obs(), e);
        end
        drain();
    endtask

    task automatic test_auipc();
        exp_t e;
        issue(32'h12345197, 32'h100, 32'hDEAD_BEEF, 32'h0);
        e = mk(1, 32'h100, 32'h1234_5000, 4'b0000, 5'd3, 1, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL auipc: got %h want %h", obs(), e); end
        drain();
    endtask

    task automatic test_illegal();
        exp_t e;
        issue(32'h4020C0B3, 32'h40, 32'h1111, 32'h2222);
        e = mk(1, 0, 0, 0, 5'd1, 0, 1);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL illegal_op_f7: got %h want %h", obs(), e); end
        issue(32'h00002083, 32'h44, 32'h3333, 32'h4444);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL illegal_load: got %h want %h", obs(), e); end
        drain();
    endtask

    task automatic test_x0();
        exp_t e;
        issue(32'h00000013, 32'h0, 32'h55, 32'h66);
        e = mk(1, 32'h55, 32'h0, 4'b0000, 5'd0, 0, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL write_x0: got %h want %h", obs(), e); end
        drain();
    endtask

    task automatic test_backpressure();
        exp_t ea, eb;
        ea = mk(1, 32'd10, 32'd20, 4'b0000, 5'd5, 1, 0);
        eb = mk(1, 32'd7, 32'h7FF, 4'b0110, 5'd6, 1, 0);
        out_rdy = 1'b1;
        issue(32'h002082B3, 32'h0, 32'd10, 32'd20);   // add x5,x1,x2
        out_rdy = 1'b0;
        instr_vld = 1'b1; instr = 32'h7FF0E313; rs1_data = 32'd7; rs2_data = 32'd0; // ori x6,x1,0x7ff
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (obs() !== ea || instr_rdy !== 1'b0) begin
                n_err++; $display("FAIL stall_%0d: got %h rdy %b want %h rdy 0", k, obs(), instr_rdy, ea);
            end
            @(posedge clk); @(negedge clk);
        end
        out_rdy = 1'b1;
        #1;
        n_vec++;
        if (instr_rdy !== 1'b1) begin n_err++; $display("FAIL unstall_rdy: got %b want 1", instr_rdy); end
        @(posedge clk); @(negedge clk);
        instr_vld = 1'b0;
        n_vec++;
        if (obs() !== eb) begin n_err++; $display("FAIL drain_accept: got %h want %h", obs(), eb); end
        drain();
        n_vec++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_vld); end
    endtask

    task automatic test_flush();
        issue(32'h002082B3, 32'h0, 32'd1, 32'd2);
        out_rdy = 1'b0;
        instr_vld = 1'b1; instr = 32'h00000013;
        @(posedge clk); @(negedge clk);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", out_vld); end
        // flush still high while an instruction is handed over: it is dropped
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (out_vld !== 1'b0) begin n_err++; $display("FAIL flush_accept: got %b want 0", out_vld); end
        drain();
    endtask

    task automatic test_async_reset();
        exp_t e;
        issue(32'h002082B3, 32'h0, 32'd3, 32'd4);
        out_rdy = 1'b0;
        instr_vld = 1'b1;
        #2 rstz = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (obs() !== e) begin n_err++; $display("FAIL async_reset: got %h want %h", obs(), e); end
        @(negedge clk);
        instr_vld = 1'b0; out_rdy = 1'b1; rstz = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t        m;
        bit          pend;
        bit          acc;
        bit          rdy_exp;
        m    = '0;
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            n_vec++;
            if (m.vld ? (obs() !== m) : (out_vld !== 1'b0)) begin
                n_err++; $display("FAIL rand_out c%0d: got %h want %h", c, obs(), m);
            end
            if (!pend) begin
                instr_vld = ($urandom_range(0, 3) != 0);
                instr     = gen_instr();
                pc        = $urandom;
                rs1_data  = $urandom;
                rs2_data  = $urandom;
            end
            out_rdy = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            #1;
            rdy_exp = !m.vld || out_rdy;
            n_vec++;
            if (instr_rdy !== rdy_exp) begin
                n_err++; $display("FAIL rand_rdy c%0d: got %b want %b", c, instr_rdy, rdy_exp);
            end
            acc  = instr_vld && rdy_exp;
            pend = instr_vld && !rdy_exp;
            if (flush)        m.vld = 1'b0;
            else if (acc)     m = ref_decode(instr, pc, rs1_data, rs2_data);
            else if (out_rdy) m.vld = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_auipc();
        test_illegal();
        test_x0();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kronos_alu_issue.md
# kronos_alu_issue

Registered operand-issue stage that drives the Kronos ALU. It accepts one fetched RV32I instruction per handshake, together with its PC and register-file read data. It decodes OP, OP-IMM, LUI and AUIPC into the ALU's `op1`/`op2`/`aluop` encoding and presents them, with destination info, through a valid/ready pipeline register. It sits between fetch/regfile read and the execute stage, which holds the combinational ALU.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rstz`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous; discard held output, takes priority over everything
- `instr_vld`  in  1  upstream instruction valid
- `instr_rdy`  out  1  upstream ready; `= ~out_vld | out_rdy` (combinational)
- `instr`  in  32  instruction word
- `pc`  in  32  instruction address
- `rs1_data`  in  32  regfile value of `instr[19:15]`
- `rs2_data`  in  32  regfile value of `instr[24:20]`
- `out_vld`  out  1  issued operation valid
- `out_rdy`  in  1  execute stage ready
- `op1`  out  32  ALU operand 1
- `op2`  out  32  ALU operand 2
- `aluop`  out  4  ALU function, `{funct7[5],funct3}` encoding
- `rd`  out  5  destination register index
- `rd_write`  out  1  writeback enable
- `illegal`  out  1  instruction not decodable by this stage

## Operation
- `aluop` codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Decode is combinational from inputs. The result is captured on `instr_vld & instr_rdy`.
- `instr[1:0] != 2'b11` makes the instruction illegal.
- OP-IMM (opcode 0010011):
  - `op1 = rs1_data`; `op2 = sign-extended instr[31:20]`.
  - `aluop = {0,funct3}`, except funct3=101, where `aluop = {instr[30],101}`.
  - funct3=001 requires `instr[31:25]=0`. funct3=101 requires `instr[31:25]` ∈ {0000000, 0100000}. Otherwise illegal.
  - For shifts, `op2` still carries the full immediate; the ALU uses only `[4:0]`.
- OP (opcode 0110011):
  - `op1 = rs1_data`; `op2 = rs2_data`; `aluop = {instr[30],funct3}`.
  - funct7=0000000 is legal with any funct3.
  - funct7=0100000 is legal only with funct3 000 or 101.
  - Any other funct7 is illegal.
- LUI (opcode 0110111): `op1 = 0`; `op2 = {instr[31:12],12'b0}`; `aluop = ADD`.
- AUIPC (opcode 0010111): `op1 = pc`; `op2 = {instr[31:12],12'b0}`; `aluop = ADD`.
- Any other opcode is illegal.
- Illegal instructions issue normally with `illegal=1`, `op1=op2=0`, `aluop=ADD`, `rd_write=0`.
- `rd = instr[11:7]`.
- `rd_write = ~illegal & (rd != 0)`.

## Timing
- Reset (`rstz=0`, async): `out_vld=0`, `op1=op2=0`, `aluop=0`, `rd=0`, `rd_write=0`, `illegal=0`. `instr_rdy` is then 1.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, with `out_vld=1`.
- Throughput is one instruction per cycle while `out_rdy=1`. Accept and drain may occur on the same edge.
- Stall (`out_vld & ~out_rdy`):
  - all outputs hold stable;
  - `instr_rdy=0`;
  - upstream must hold its inputs.
- Register update per edge:
  - on `flush`: `out_vld←0`; the payload may hold.
  - else on accept: the payload loads and `out_vld←1`.
  - else on `out_rdy`: `out_vld←0`.
- `flush` together with `instr_vld & instr_rdy`: the incoming instruction is dropped and `out_vld=0` next cycle.
- `out_vld` never depends combinationally on `out_rdy`. `instr_rdy` does.
- Reset mid-stall discards the held instruction immediately.

## Test plan
- ADDI: `instr=0xFFF08093` (addi x1,x1,-1), `rs1_data=5`, `out_rdy=1` → next cycle `out_vld=1`, `op1=5`, `op2=0xFFFFFFFF`, `aluop=0000`, `rd=1`, `rd_write=1`, `illegal=0`.
- SUB then SRAI back-to-back with `out_rdy=1`:
  - `0x40208133` → `aluop=1000`, `op2=rs2_data`;
  - `0x4030D113` → `aluop=1101`, `op2[4:0]=3`;
  - both are accepted on consecutive edges with no bubble.
- AUIPC `0x12345197`, `pc=0x100` → `op1=0x100`, `op2=0x12345000`, `aluop=0000`, `rd=3`.
- Illegal cases → `illegal=1`, `rd_write=0`, `aluop=0`, `op1=op2=0`:
  - OP with funct7=0100000, funct3=100 (`0x4020C0B3`);
  - opcode 0000011.
- Write to x0: `addi x0,x0,0` (`0x00000013`) → `rd=0`, `rd_write=0`, `illegal=0`.
- Backpressure:
  - hold `out_rdy=0` for 3 cycles with `instr_vld=1` → outputs stable and `instr_rdy=0` throughout; raising `out_rdy` drains and accepts on the same edge.
  - Assert `flush` during the stall → `out_vld=0` next cycle.
  - Assert `rstz=0` asynchronously mid-stall → `out_vld=0` without waiting for a clock edge.
